// File: rtl/mem_resp_if.sv
// Request/response bundle between the MDR and the memory responder mem_resp.
interface mem_resp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  ack;
  logic                  busy;

  modport master (
    output req, we, addr, ram_wr_data,
    input  ram_rd_data, ack, busy
  );

  modport slave (
    input  req, we, addr, ram_wr_data,
    output ram_rd_data, ack, busy
  );
endinterface

// File: rtl/mem_resp.sv
// Single-word RAM responder with fixed wait states and a one-cycle ack pulse.
// Optional macro MEM_INIT_CLEAR_EN adds a post-reset sweep that zeroes the RAM.
module mem_resp #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
);
  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

`ifdef MEM_INIT_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2, ST_CLEAR = 2'd3} state_t;
  localparam state_t RST_STATE = ST_CLEAR;
  localparam logic   RST_BUSY  = 1'b1;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2} state_t;
  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  accept_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef MEM_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
`endif

  // Next-state, request capture, commit and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    ack_d       = 1'b0;
    accept_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_q;
    mem_wdata_s = wdata_q;
`ifdef MEM_INIT_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        accept_s = bus.req;
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (we_q) begin
            mem_we_s = 1'b1;
          end else begin
            rd_data_d = mem_q[addr_q];
          end
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
      end
      // Leaving ACK doubles as an accept slot so held requests stream without a gap.
      ST_ACK: begin
        accept_s = bus.req;
        state_d  = ST_IDLE;
      end
`ifdef MEM_INIT_CLEAR_EN
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_addr_q;
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (accept_s) begin
      state_d = ST_WAIT;
      cnt_d   = WAIT_LD;
      addr_d  = bus.addr;
      we_d    = bus.we;
      wdata_d = bus.ram_wr_data;
    end else begin
      state_d = state_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Control, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      cnt_q      <= 4'd0;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      we_q       <= 1'b0;
      wdata_q    <= {DATA_WIDTH{1'b0}};
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      ack_q      <= 1'b0;
      busy_q     <= RST_BUSY;
`ifdef MEM_INIT_CLEAR_EN
      clr_addr_q <= {ADDR_WIDTH{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
`ifdef MEM_INIT_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  // RAM array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign bus.ram_rd_data = rd_data_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mem_resp.sv
// Directed plus randomized bench for mem_resp against a word-level RAM model.
module tb_mem_resp;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int WS  = 2;
  localparam int LAT = WS + 2;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  logic [DW-1:0] model_mem [16];
  bit            known     [16];
  logic [DW-1:0] model_rd;

  mem_resp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset for 'cycles' edges, release, and check the post-reset behaviour.
  task automatic reset_seq(input int cycles, input bit hold_req);
    int n;
    rst             = 1'b1;
    bus.req         = hold_req;
    bus.we          = 1'b0;
    bus.addr        = 4'd0;
    bus.ram_wr_data = 8'd0;
    repeat (cycles) @(negedge clk);
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_rd_data", 32'(bus.ram_rd_data), 32'd0);
    model_rd = 8'd0;
    rst = 1'b0;
`ifdef MEM_INIT_CLEAR_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    chk("clear_busy_cycles", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'd0;
      known[i]     = 1'b1;
    end
`else
    n = 0;
    chk("reset_busy", 32'(bus.busy), 32'(n));
    @(negedge clk);
    chk("first_cycle_busy", 32'(bus.busy), 32'd0);
    chk("first_cycle_ack", 32'(bus.ack), 32'd0);
`endif
  endtask

  // One access: drive (unless already driven), track busy/ack per cycle, check read data at ack.
  task automatic xfer(input bit w, input logic [3:0] a, input logic [7:0] d,
                      input bit predriven, input int junk_mode,
                      input bit chain, input bit cw, input logic [3:0] ca, input logic [7:0] cd);
    logic [7:0] exp_rd;
    if (!predriven) begin
      bus.req         = 1'b1;
      bus.we          = w;
      bus.addr        = a;
      bus.ram_wr_data = d;
    end
    exp_rd = w ? model_rd : model_mem[a];
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("busy_in_flight", 32'(bus.busy), 32'd1);
      chk("ack_timing", 32'(bus.ack), 32'(k == LAT));
      if (k == LAT) chk("rd_data_at_ack", 32'(bus.ram_rd_data), 32'(exp_rd));
      if (k < LAT) begin
        if (junk_mode == 1) begin
          bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'd2; bus.ram_wr_data = 8'hFF;
        end else begin
          bus.req         = 1'($urandom_range(0, 1));
          bus.we          = 1'($urandom_range(0, 1));
          bus.addr        = 4'($urandom);
          bus.ram_wr_data = 8'($urandom);
        end
      end else if (chain) begin
        bus.req = 1'b1; bus.we = cw; bus.addr = ca; bus.ram_wr_data = cd;
      end else begin
        bus.req         = 1'b0;
        bus.we          = 1'($urandom_range(0, 1));
        bus.addr        = 4'($urandom);
        bus.ram_wr_data = 8'($urandom);
      end
    end
    if (w) begin
      model_mem[a] = d;
      known[a]     = 1'b1;
    end else begin
      model_rd = exp_rd;
    end
    if (!chain) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_ack", 32'(bus.ack), 32'd0);
    end
  endtask

  initial begin : stim
    bit         cw, nw, ch, pre;
    logic [3:0] ca, na;
    logic [7:0] cd, nd;
    n_assert = 0;
    n_fail   = 0;
    model_rd = 8'd0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'd0;
      known[i]     = 1'b0;
    end

`ifdef MEM_INIT_CLEAR_EN
    reset_seq(2, 1'b1);
    xfer(1'b0, 4'd0, 8'd0, 1'b1, 0, 1'b0, 1'b0, 4'd0, 8'd0);
    xfer(1'b0, 4'd7, 8'd0, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);
    xfer(1'b0, 4'd15, 8'd0, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);
`else
    reset_seq(2, 1'b0);
`endif

    // Write then read back; read data must not move on the write
    xfer(1'b1, 4'd5, 8'hC3, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);
    xfer(1'b0, 4'd5, 8'h00, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Back-to-back write then read of the same word
    xfer(1'b1, 4'hF, 8'h66, 1'b0, 0, 1'b1, 1'b0, 4'hF, 8'h00);
    xfer(1'b0, 4'hF, 8'h00, 1'b1, 0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Requests while busy are ignored
    xfer(1'b1, 4'd2, 8'h3C, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);
    xfer(1'b1, 4'd9, 8'h81, 1'b0, 1, 1'b0, 1'b0, 4'd0, 8'd0);
    xfer(1'b0, 4'd2, 8'h00, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Reset in the first WAIT cycle aborts an uncommitted write
    xfer(1'b1, 4'd3, 8'h55, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'd3; bus.ram_wr_data = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_wait", 32'(bus.busy), 32'd1);
    reset_seq(1, 1'b0);
    xfer(1'b0, 4'd3, 8'h00, 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Fill every word, then random mix with random chaining
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 4'(i), 8'($urandom), 1'b0, 0, 1'b0, 1'b0, 4'd0, 8'd0);
    end
    cw = 1'($urandom_range(0, 1)); ca = 4'($urandom); cd = 8'($urandom);
    pre = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nw = 1'($urandom_range(0, 1)); na = 4'($urandom); nd = 8'($urandom);
      ch = (i < 39) && ($urandom_range(0, 1) == 1);
      xfer(cw, ca, cd, pre, 0, ch, nw, na, nd);
      cw = nw; ca = na; cd = nd; pre = ch;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
